// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package adc_capture_pkg;

  localparam int unsigned DEPTH = 5000;
  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_t;

  // Next RAM address; wraps from depth-1 back to 0 so unused codes are never produced.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] addr, input int unsigned depth);
    if (32'(addr) >= depth - 1) return '0;
    return addr + AW'(1);
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Write-side bus of the capture sequencer onto port 2 of the sample RAM.
interface adc_capture_ctrl_if
  import adc_capture_pkg::*;
#(
  parameter int unsigned AW = adc_capture_pkg::AW,
  parameter int unsigned DW = adc_capture_pkg::DW
);

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic          mem_chipselect;
  logic          mem_write;
  logic [1:0]    mem_byteenable;

  modport master (
    output mem_address, mem_writedata, mem_chipselect, mem_write, mem_byteenable
  );

  modport slave (
    input mem_address, mem_writedata, mem_chipselect, mem_write, mem_byteenable
  );

endinterface

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger detector: remembers the previous valid sample and flags
// a rising or falling crossing of the threshold, or a forced trigger.
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int unsigned DW = adc_capture_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 adc_valid,
  input  logic signed [DW-1:0] adc_data,
  input  logic signed [DW-1:0] trig_level,
  input  logic                 trig_rising,
  input  logic                 force_trig,
  output logic                 hit
);

  logic signed [DW-1:0] prev;
  logic                 prev_vld;
  logic                 cross_hit;

  // Previous-sample history; invalidated at the start of each capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (clear) begin
      prev_vld <= 1'b0;
    end else if (adc_valid) begin
      prev     <= adc_data;
      prev_vld <= 1'b1;
    end
  end

  // Edge compare against the threshold; only a valid history can produce an edge.
  always_comb begin
    cross_hit = 1'b0;
    if (prev_vld) begin
      if (trig_rising) cross_hit = (prev < trig_level) && (adc_data >= trig_level);
      else             cross_hit = (prev >= trig_level) && (adc_data < trig_level);
    end
    hit = adc_valid && en && (force_trig || cross_hit);
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer owning RAM port 2: streams ADC samples into the RAM, waits
// for a level trigger, stores the post-trigger samples and freezes.
// Optional feature: define ADC_CAPTURE_PRETRIG_EN for circular pre-trigger history.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned DEPTH = adc_capture_pkg::DEPTH,
  parameter int unsigned AW    = adc_capture_pkg::AW,
  parameter int unsigned DW    = adc_capture_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adc_valid,
  input  logic signed [DW-1:0] adc_data,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [AW-1:0]        post_count,
  input  logic signed [DW-1:0] trig_level,
  input  logic                 trig_rising,
  input  logic                 force_trig,
  adc_capture_ctrl_if.master   mem,
  output logic                 busy,
  output logic                 triggered,
  output logic                 done,
  output logic [AW-1:0]        trig_addr,
  output logic [AW-1:0]        start_addr
);

`ifdef ADC_CAPTURE_PRETRIG_EN
  localparam bit PRETRIG = 1'b1;
`else
  localparam bit PRETRIG = 1'b0;
`endif

  state_t               state, state_nxt;
  logic [AW-1:0]        post_q, remain, fill_cnt, wr_ptr, post_clamped;
  logic signed [DW-1:0] level_q;
  logic                 rising_q;
  logic                 start, hit, accept, writing, in_armed;

  logic                 vld_p1;
  logic [AW-1:0]        addr_p1;
  logic signed [DW-1:0] data_p1;

  // Saturate the requested post-trigger length into 1..DEPTH.
  function automatic logic [AW-1:0] clamp_post(input logic [AW-1:0] pc);
    if (pc == '0) return AW'(1);
    if (32'(pc) > DEPTH) return AW'(DEPTH);
    return pc;
  endfunction

  assign in_armed = (state == ST_ARMED);

  adc_trig_detect #(.DW(DW)) u_trig (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start),
    .en         (in_armed),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trig_level (level_q),
    .trig_rising(rising_q),
    .force_trig (force_trig),
    .hit        (hit)
  );

  // Next-state and write-acceptance decode; abort beats everything, including arm.
  always_comb begin
    post_clamped = clamp_post(post_count);
    start        = arm && !abort && (state == ST_IDLE || state == ST_DONE);
    writing      = (state == ST_FILL) || (state == ST_POST) || (in_armed && (PRETRIG || hit));
    accept       = adc_valid && writing && !abort;
    state_nxt    = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm) state_nxt = (PRETRIG && post_clamped != AW'(DEPTH)) ? ST_FILL : ST_ARMED;
        ST_FILL:          if (adc_valid && fill_cnt == AW'(1)) state_nxt = ST_ARMED;
        ST_ARMED:         if (hit) state_nxt = (post_q == AW'(1)) ? ST_DONE : ST_POST;
        ST_POST:          if (adc_valid && remain == AW'(1)) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Capture control: latched setup, write pointer, counters and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      post_q     <= '0;
      remain     <= '0;
      fill_cnt   <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      rising_q   <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      triggered  <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (accept) wr_ptr <= addr_inc(wr_ptr, DEPTH);
      if (start) begin
        post_q     <= post_clamped;
        fill_cnt   <= AW'(DEPTH) - post_clamped;
        wr_ptr     <= '0;
        level_q    <= trig_level;
        rising_q   <= trig_rising;
        trig_addr  <= '0;
        start_addr <= '0;
      end
      if (!abort && state == ST_FILL && adc_valid) fill_cnt <= fill_cnt - AW'(1);
      if (!abort && hit) begin
        trig_addr <= wr_ptr;
        remain    <= post_q - AW'(1);
      end
      if (accept && state == ST_POST) remain <= remain - AW'(1);
      // Oldest surviving sample sits just past the final write.
      if (state != ST_DONE && state_nxt == ST_DONE)
        start_addr <= PRETRIG ? addr_inc(wr_ptr, DEPTH) : '0;
      triggered <= (triggered && !abort && !start) || (hit && !abort);
      done      <= (state == ST_DONE) && (state_nxt == ST_DONE);
    end
  end

  // ---- stage p1: registered RAM write, one cycle after the sample is accepted ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= wr_ptr;
        data_p1 <= adc_data;
      end
    end
  end

  assign mem.mem_address    = addr_p1;
  assign mem.mem_writedata  = data_p1;
  assign mem.mem_write      = vld_p1;
  assign mem.mem_chipselect = vld_p1;
  assign mem.mem_byteenable = {2{vld_p1}};

  assign busy = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed testbench for adc_capture_ctrl (default build; pre-trigger checks when
// ADC_CAPTURE_PRETRIG_EN is defined).
module tb_adc_capture_ctrl;
  import adc_capture_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, adc_valid, arm, abort, trig_rising, force_trig;
  logic signed [15:0] adc_data, trig_level;
  logic [12:0]        post_count;
  logic               busy, triggered, done;
  logic [12:0]        trig_addr, start_addr;

  adc_capture_ctrl_if mem_bus ();

  adc_capture_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .arm        (arm),
    .abort      (abort),
    .post_count (post_count),
    .trig_level (trig_level),
    .trig_rising(trig_rising),
    .force_trig (force_trig),
    .mem        (mem_bus),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr),
    .start_addr (start_addr)
  );

  // Write log taken on the falling edge, away from the active edge.
  logic [12:0] wlog_addr[$];
  logic [15:0] wlog_data[$];
  int          wr_count = 0;
  int          bus_bad  = 0;
  always @(negedge clk) begin
    if (mem_bus.mem_write) begin
      wlog_addr.push_back(mem_bus.mem_address);
      wlog_data.push_back(mem_bus.mem_writedata);
      wr_count++;
    end
    if (mem_bus.mem_byteenable != {2{mem_bus.mem_write}} || mem_bus.mem_chipselect != mem_bus.mem_write)
      bus_bad++;
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] d16(input int v);
    logic [15:0] t;
    t = 16'(v);
    return {16'd0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    adc_data  = 16'(v);
    adc_valid = 1'b1;
    tick();
  endtask

  task automatic do_arm(input int pc, input int lvl, input logic rise);
    post_count  = 13'(pc);
    trig_level  = 16'(lvl);
    trig_rising = rise;
    adc_valid   = 1'b0;
    arm         = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   base;
    int   bad;
    logic any_out;

    reset_n = 1'b0; adc_valid = 1'b0; adc_data = '0; arm = 1'b0; abort = 1'b0;
    post_count = '0; trig_level = '0; trig_rising = 1'b1; force_trig = 1'b0;
    any_out = 1'b0;

    // Reset held with valid toggling and a stray arm.
    for (int i = 0; i < 6; i++) begin
      adc_valid  = i[0];
      force_trig = i[0];
      arm        = (i == 2);
      tick();
      any_out = any_out | busy | triggered | done | mem_bus.mem_write | mem_bus.mem_chipselect
              | (mem_bus.mem_address != 0) | (mem_bus.mem_writedata != 0)
              | (trig_addr != 0) | (start_addr != 0);
    end
    check("reset_outputs_zero", 32'(any_out), 32'd0);
    check("reset_no_writes", 32'(wr_count), 32'd0);

    reset_n = 1'b1; arm = 1'b0; force_trig = 1'b0;
    feed(1); feed(2); feed(3);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("idle_no_writes", 32'(wr_count), 32'd0);

    // arm and abort together: abort wins.
    adc_valid = 1'b0; arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_same_cycle", 32'(busy), 32'd0);
    force_trig = 1'b1;
    feed(5); feed(6);
    force_trig = 1'b0;
    check("arm_abort_no_writes", 32'(wr_count), 32'd0);

`ifndef ADC_CAPTURE_PRETRIG_EN
    // Ramp -100..100, rising through 0, ten post samples.
    do_arm(10, 0, 1'b1);
    check("ramp_armed_busy", 32'(busy), 32'd1);
    base = wr_count;
    for (int v = -100; v <= 100; v++) begin
      feed(v);
      if (v == -1) check("ramp_no_early_trig", 32'(triggered), 32'd0);
      if (v == 0) begin
        check("ramp_trig_write", 32'(mem_bus.mem_write), 32'd1);
        check("ramp_trig_addr", 32'(mem_bus.mem_address), 32'd0);
        check("ramp_trig_data", 32'(mem_bus.mem_writedata), d16(0));
        check("ramp_triggered", 32'(triggered), 32'd1);
      end
      if (v == 9) begin
        check("ramp_last_addr", 32'(mem_bus.mem_address), 32'd9);
        check("ramp_done_not_yet", 32'(done), 32'd0);
      end
      if (v == 10) begin
        check("ramp_done_rise", 32'(done), 32'd1);
        check("ramp_write_stops", 32'(mem_bus.mem_write), 32'd0);
      end
    end
    check("ramp_write_count", 32'(wr_count - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("ramp_log_addr", 32'(wlog_addr[base+i]), 32'(i));
      check("ramp_log_data", 32'(wlog_data[base+i]), d16(i));
    end
    check("ramp_done_held", 32'(done), 32'd1);
    check("ramp_addr_frozen", 32'(mem_bus.mem_address), 32'd9);
    check("ramp_trig_addr_out", 32'(trig_addr), 32'd0);
    check("ramp_start_addr_out", 32'(start_addr), 32'd0);
    check("ramp_idle_busy", 32'(busy), 32'd0);

    // Falling edge: stale history is 100, first sample below level must not fire.
    adc_valid = 1'b0;
    do_arm(3, 0, 1'b0);
    check("fall_rearm_clears", 32'(triggered) + 32'(done), 32'd0);
    base = wr_count;
    feed(-5);
    check("fall_first_no_trig", 32'(triggered), 32'd0);
    for (int i = 0; i < 50; i++) feed(10);
    check("fall_no_writes_armed", 32'(wr_count - base), 32'd0);
    feed(-3);
    check("fall_trig", 32'(triggered), 32'd1);
    check("fall_trig_addr", 32'(mem_bus.mem_address), 32'd0);
    check("fall_trig_data", 32'(mem_bus.mem_writedata), d16(-3));
    feed(7); feed(8);
    check("fall_post_addr", 32'(mem_bus.mem_address), 32'd2);
    feed(9);
    check("fall_done", 32'(done), 32'd1);
    check("fall_write_count", 32'(wr_count - base), 32'd3);

    // Forced trigger, arm ignored while busy, then abort during POST.
    adc_valid = 1'b0;
    do_arm(20, 0, 1'b1);
    base = wr_count;
    force_trig = 1'b1;
    feed(-50);
    force_trig = 1'b0;
    check("force_trig", 32'(triggered), 32'd1);
    feed(-50); feed(-50);
    post_count = 13'd2; arm = 1'b1;
    feed(-50);
    arm = 1'b0;
    check("arm_busy_addr", 32'(mem_bus.mem_address), 32'd3);
    feed(-50); feed(-50); feed(-50);
    check("arm_busy_ignored", 32'(busy), 32'd1);
    check("arm_busy_addr_cont", 32'(mem_bus.mem_address), 32'd6);
    abort = 1'b1;
    feed(-50);
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_write", 32'(mem_bus.mem_write), 32'd0);
    check("abort_done_low", 32'(done), 32'd0);
    check("abort_trig_low", 32'(triggered), 32'd0);
    for (int i = 0; i < 5; i++) feed(-50);
    check("abort_write_count", 32'(wr_count - base), 32'd7);

    // post_count = 0 behaves as a single write.
    adc_valid = 1'b0;
    do_arm(0, 0, 1'b1);
    base = wr_count;
    force_trig = 1'b1;
    feed(1);
    force_trig = 1'b0;
    check("pc0_write", 32'(mem_bus.mem_write), 32'd1);
    feed(2);
    check("pc0_done", 32'(done), 32'd1);
    check("pc0_count", 32'(wr_count - base), 32'd1);

    // post_count = 6000 saturates to a full RAM of writes.
    adc_valid = 1'b0;
    do_arm(6000, 0, 1'b1);
    base = wr_count;
    force_trig = 1'b1;
    feed(0);
    force_trig = 1'b0;
    for (int k = 1; k <= 5001; k++) begin
      feed(k);
      if (k == 4999) check("pc6000_not_done", 32'(done), 32'd0);
      if (k == 5000) check("pc6000_done", 32'(done), 32'd1);
    end
    check("pc6000_count", 32'(wr_count - base), 32'd5000);
    check("pc6000_last_addr", 32'(wlog_addr[base+4999]), 32'd4999);
    bad = 0;
    for (int i = 0; i < 5000; i++) if (32'(wlog_addr[base+i]) != 32'(i)) bad++;
    check("pc6000_addr_seq", 32'(bad), 32'd0);
`else
    // Forced trigger held from arm: FILL must absorb exactly 4000 writes first.
    do_arm(1000, 32767, 1'b1);
    base = wr_count;
    force_trig = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      feed(k);
      if (k == 3999) check("pre_fill_no_trig", 32'(triggered), 32'd0);
      if (k == 4000) check("pre_trig_after_fill", 32'(triggered), 32'd1);
    end
    force_trig = 1'b0;
    feed(0);
    check("pre_fill_done", 32'(done), 32'd1);
    check("pre_fill_trig_addr", 32'(trig_addr), 32'd4000);
    check("pre_fill_start_addr", 32'(start_addr), 32'd0);
    check("pre_fill_count", 32'(wr_count - base), 32'd5000);

    // Counter data crossing 7000: circular history wraps 4999 -> 0.
    adc_valid = 1'b0;
    do_arm(1000, 7000, 1'b1);
    base = wr_count;
    for (int k = 0; k <= 8000; k++) feed(k);
    check("pre_wrap_hi", 32'(wlog_addr[base+4999]), 32'd4999);
    check("pre_wrap_lo", 32'(wlog_addr[base+5000]), 32'd0);
    check("pre_trig_addr", 32'(trig_addr), 32'd2000);
    check("pre_start_addr", 32'(start_addr), 32'd3000);
    check("pre_count", 32'(wr_count - base), 32'd8000);
    check("pre_done", 32'(done), 32'd1);
`endif

    adc_valid = 1'b0;
    tick();
    check("bus_strobes_consistent", 32'(bus_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
